// File: rtl/sdspi_pkg.sv
// Shared SD-over-SPI definitions: CRC7 polynomial, R1 bits, response codes, card FSM states.
package sdspi_pkg;

    localparam int unsigned CMD_W   = 6;
    localparam int unsigned ARG_W   = 32;
    localparam int unsigned CRC_W   = 7;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned RSP_W   = 40;
    localparam int unsigned CNT_W   = 3;

    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    // R1 bit positions
    localparam int unsigned R1_IDLE      = 0;
    localparam int unsigned R1_ERASE_RST = 1;
    localparam int unsigned R1_ILLEGAL   = 2;
    localparam int unsigned R1_CRC_ERR   = 3;
    localparam int unsigned R1_ERASE_SEQ = 4;
    localparam int unsigned R1_ADDRESS   = 5;
    localparam int unsigned R1_PARAM     = 6;

    localparam logic [BYTE_W-1:0] R1_CRC_ERR_BYTE = 8'(1 << R1_CRC_ERR);
    localparam logic [BYTE_W-1:0] FILL_BYTE       = 8'hff;
    localparam logic [BYTE_W-1:0] BUSY_BYTE       = 8'h00;

    // Response-type codes; bit 1 set means R1 followed by four payload bytes
    localparam logic [1:0] RSP_R1   = 2'b00;
    localparam logic [1:0] RSP_R1B  = 2'b01;
    localparam logic [1:0] RSP_R3R7 = 2'b10;

    typedef struct packed {
        logic [BYTE_W-1:0] r1;
        logic [ARG_W-1:0]  payload;
    } rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_BUSY = 3'd4
    } state_t;

endpackage

// File: rtl/spicard_cmd_if.sv
// Byte link, command and response handshake between the SPI card front end and its controller.
interface spicard_cmd_if;
    import sdspi_pkg::*;

    logic                i_cs_n;
    logic                i_ll_stb;
    logic [BYTE_W-1:0]   i_ll_byte;
    logic [BYTE_W-1:0]   o_ll_byte;
    logic                o_cmd_stb;
    logic [CMD_W-1:0]    o_cmd;
    logic [ARG_W-1:0]    o_cmd_data;
    logic                o_crc_err;
    logic                o_rsp_ready;
    logic                i_rsp_stb;
    logic [1:0]          i_rsp_type;
    logic [RSP_W-1:0]    i_rsp;
    logic                i_busy;

    modport slave (
        input  i_cs_n, i_ll_stb, i_ll_byte, i_rsp_stb, i_rsp_type, i_rsp, i_busy,
        output o_ll_byte, o_cmd_stb, o_cmd, o_cmd_data, o_crc_err, o_rsp_ready
    );

    modport master (
        output i_cs_n, i_ll_stb, i_ll_byte, i_rsp_stb, i_rsp_type, i_rsp, i_busy,
        input  o_ll_byte, o_cmd_stb, o_cmd, o_cmd_data, o_crc_err, o_rsp_ready
    );

endinterface

// File: rtl/spicrc7_byte.sv
// Combinational CRC7 (x^7+x^3+1) update over one byte, MSB first.
module spicrc7_byte
    import sdspi_pkg::*;
(
    input  logic [CRC_W-1:0]  crc,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc_next
);

    logic [CRC_W-1:0] acc;

    // Eight serial shift steps unrolled
    always_comb begin
        acc = crc;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            if (acc[CRC_W-1] ^ data[i]) begin
                acc = {acc[CRC_W-2:0], 1'b0} ^ CRC7_POLY;
            end else begin
                acc = {acc[CRC_W-2:0], 1'b0};
            end
        end
        crc_next = acc;
    end

endmodule

// File: rtl/spicard_cmd.sv
// Card-side SD-over-SPI command parser and R1/R1b/R3/R7 responder on a byte-level link.
module spicard_cmd
    import sdspi_pkg::*;
#(
    parameter bit OPT_CRC_CHECK = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    spicard_cmd_if.slave  bus
);

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [CNT_W-1:0]    idx, idx_d;
    logic [CRC_W-1:0]    crc, crc_d, crc_in, crc_nx;
    logic [CMD_W-1:0]    cmd, cmd_d;
    logic [ARG_W-1:0]    arg, arg_d;
    logic [BYTE_W-1:0]   ll_byte, ll_byte_d;
    logic                cmd_stb, cmd_stb_d;
    logic                crc_err, crc_err_d;
    logic                rsp_ready, rsp_ready_d;
    logic [1:0]          rtype, rtype_d;
    logic [ARG_W-1:0]    pay, pay_d;
    logic                frame_ok;
    rsp_t                rsp_in;

    assign rsp_in = rsp_t'(bus.i_rsp);
    // A new frame restarts the CRC from zero
    assign crc_in = (state == ST_IDLE) ? '0 : crc;

    spicrc7_byte u_crc (
        .crc      (crc_in),
        .data     (bus.i_ll_byte),
        .crc_next (crc_nx)
    );

    assign frame_ok = !OPT_CRC_CHECK ||
                      ((bus.i_ll_byte[7:1] == crc) && bus.i_ll_byte[0]);

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            crc       <= '0;
            cmd       <= '0;
            arg       <= '0;
            ll_byte   <= FILL_BYTE;
            cmd_stb   <= 1'b0;
            crc_err   <= 1'b0;
            rsp_ready <= 1'b0;
            rtype     <= RSP_R1;
            pay       <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            crc       <= crc_d;
            cmd       <= cmd_d;
            arg       <= arg_d;
            ll_byte   <= ll_byte_d;
            cmd_stb   <= cmd_stb_d;
            crc_err   <= crc_err_d;
            rsp_ready <= rsp_ready_d;
            rtype     <= rtype_d;
            pay       <= pay_d;
        end
    end

    // Next-state and next-output logic; only link strobes advance the frame and response
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        idx_d       = idx;
        crc_d       = crc;
        cmd_d       = cmd;
        arg_d       = arg;
        ll_byte_d   = ll_byte;
        cmd_stb_d   = 1'b0;
        crc_err_d   = 1'b0;
        rsp_ready_d = rsp_ready;
        rtype_d     = rtype;
        pay_d       = pay;

        if (bus.i_cs_n) begin
            // Deselect aborts everything but keeps the last command visible
            state_d     = ST_IDLE;
            cnt_d       = '0;
            idx_d       = '0;
            crc_d       = '0;
            ll_byte_d   = FILL_BYTE;
            rsp_ready_d = 1'b0;
            rtype_d     = RSP_R1;
            pay_d       = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    ll_byte_d = FILL_BYTE;
                    if (bus.i_ll_stb && bus.i_ll_byte[7:6] == 2'b01) begin
                        cmd_d   = bus.i_ll_byte[5:0];
                        arg_d   = '0;
                        crc_d   = crc_nx;
                        cnt_d   = 3'd1;
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (bus.i_ll_stb) begin
                        if (cnt == 3'd5) begin
                            cnt_d = '0;
                            if (frame_ok) begin
                                cmd_stb_d   = 1'b1;
                                rsp_ready_d = 1'b1;
                                state_d     = ST_WAIT;
                            end else begin
                                crc_err_d = 1'b1;
                                ll_byte_d = R1_CRC_ERR_BYTE;
                                rtype_d   = RSP_R1;
                                idx_d     = '0;
                                state_d   = ST_SEND;
                            end
                        end else begin
                            arg_d = {arg[ARG_W-9:0], bus.i_ll_byte};
                            crc_d = crc_nx;
                            cnt_d = CNT_W'(cnt + 3'd1);
                        end
                    end
                end
                ST_WAIT: begin
                    ll_byte_d = FILL_BYTE;
                    if (bus.i_rsp_stb) begin
                        rtype_d     = bus.i_rsp_type;
                        pay_d       = rsp_in.payload;
                        ll_byte_d   = rsp_in.r1;
                        rsp_ready_d = 1'b0;
                        idx_d       = '0;
                        state_d     = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.i_ll_stb) begin
                        if (rtype[1]) begin
                            if (idx == 3'd4) begin
                                ll_byte_d = FILL_BYTE;
                                state_d   = ST_IDLE;
                            end else begin
                                ll_byte_d = pay[ARG_W-1 -: BYTE_W];
                                pay_d     = {pay[ARG_W-9:0], 8'h00};
                                idx_d     = CNT_W'(idx + 3'd1);
                            end
                        end else if (rtype == RSP_R1B) begin
                            ll_byte_d = bus.i_busy ? BUSY_BYTE : FILL_BYTE;
                            state_d   = ST_BUSY;
                        end else begin
                            ll_byte_d = FILL_BYTE;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                ST_BUSY: begin
                    ll_byte_d = bus.i_busy ? BUSY_BYTE : FILL_BYTE;
                    if (bus.i_ll_stb && ll_byte == FILL_BYTE) begin
                        ll_byte_d = FILL_BYTE;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    ll_byte_d = FILL_BYTE;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ll_byte   = ll_byte;
    assign bus.o_cmd_stb   = cmd_stb;
    assign bus.o_cmd       = cmd;
    assign bus.o_cmd_data  = arg;
    assign bus.o_crc_err   = crc_err;
    assign bus.o_rsp_ready = rsp_ready;

endmodule

// File: tb/tb_spicard_cmd.sv
// Scoreboard bench for spicard_cmd: MISO bytes and commands are queued when driven and checked as they appear.
module tb_spicard_cmd;

    typedef logic [7:0] frame_t [6];

    logic clk;
    logic rst;

    spicard_cmd_if bus0 ();
    spicard_cmd_if bus1 ();

    spicard_cmd #(.OPT_CRC_CHECK(1'b1)) dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0.slave));
    spicard_cmd #(.OPT_CRC_CHECK(1'b0)) dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1.slave));

    // The CRC-agnostic instance sees exactly the same stimulus
    assign bus1.i_cs_n     = bus0.i_cs_n;
    assign bus1.i_ll_stb   = bus0.i_ll_stb;
    assign bus1.i_ll_byte  = bus0.i_ll_byte;
    assign bus1.i_rsp_stb  = bus0.i_rsp_stb;
    assign bus1.i_rsp_type = bus0.i_rsp_type;
    assign bus1.i_rsp      = bus0.i_rsp;
    assign bus1.i_busy     = bus0.i_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]  miso_q [$];
    logic [37:0] cmd_q  [$];

    int stb0 = 0, err0 = 0, stb1 = 0, err1 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MISO scoreboard: the byte the link latches on each strobe
    always @(negedge clk) begin
        if (bus0.i_ll_stb) begin
            if (miso_q.size() == 0) begin
                check("miso_unexpected", 64'(bus0.o_ll_byte), 64'h1ff);
            end else begin
                check("miso", 64'(bus0.o_ll_byte), 64'(miso_q.pop_front()));
            end
        end
    end

    // Command scoreboard and pulse counters
    always @(negedge clk) begin
        if (bus0.o_cmd_stb) begin
            stb0++;
            if (cmd_q.size() == 0) begin
                check("cmd_unexpected", 64'({bus0.o_cmd, bus0.o_cmd_data}), 64'h1);
            end else begin
                check("cmd", 64'({bus0.o_cmd, bus0.o_cmd_data}), 64'(cmd_q.pop_front()));
            end
        end
        if (bus0.o_crc_err) err0++;
        if (bus1.o_cmd_stb) stb1++;
        if (bus1.o_crc_err) err1++;
    end

    task automatic slot(input logic [7:0] mosi, input logic [7:0] exp_miso);
        miso_q.push_back(exp_miso);
        bus0.i_ll_stb  = 1'b1;
        bus0.i_ll_byte = mosi;
        @(posedge clk); #1;
        bus0.i_ll_stb  = 1'b0;
        bus0.i_ll_byte = 8'hff;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < 6; i++) slot(f[i], 8'hff);
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        while (!bus0.o_rsp_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_ready", 64'(bus0.o_rsp_ready), 64'h1);
    endtask

    task automatic respond(input logic [1:0] rtype, input logic [39:0] rsp, input bit with_stb);
        bus0.i_rsp_stb  = 1'b1;
        bus0.i_rsp_type = rtype;
        bus0.i_rsp      = rsp;
        if (with_stb) begin
            miso_q.push_back(8'hff);
            bus0.i_ll_stb  = 1'b1;
            bus0.i_ll_byte = 8'hff;
        end
        @(posedge clk); #1;
        bus0.i_rsp_stb = 1'b0;
        bus0.i_ll_stb  = 1'b0;
        check("rsp_ready_drop", 64'(bus0.o_rsp_ready), 64'h0);
        @(posedge clk); #1;
    endtask

    frame_t f_cmd0, f_cmd0_bad, f_cmd8, f_cmd55;
    int s0, e0, s1, e1;

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        f_cmd0     = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        f_cmd0_bad = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h94};
        f_cmd8     = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
        f_cmd55    = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65};

        rst             = 1'b1;
        bus0.i_cs_n     = 1'b0;
        bus0.i_ll_stb   = 1'b0;
        bus0.i_ll_byte  = 8'hff;
        bus0.i_rsp_stb  = 1'b0;
        bus0.i_rsp_type = 2'b00;
        bus0.i_rsp      = '0;
        bus0.i_busy     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ll_byte", 64'(bus0.o_ll_byte), 64'hff);
        check("rst_rsp_ready", 64'(bus0.o_rsp_ready), 64'h0);
        check("rst_cmd_stb", 64'(bus0.o_cmd_stb), 64'h0);
        check("rst_crc_err", 64'(bus0.o_crc_err), 64'h0);
        check("rst_cmd", 64'({bus0.o_cmd, bus0.o_cmd_data}), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // CMD0, R1 = 01, with two Ncr fill slots while waiting
        e0 = err0;
        cmd_q.push_back({6'd0, 32'h0});
        send_frame(f_cmd0);
        wait_ready();
        slot(8'hff, 8'hff);
        slot(8'hff, 8'hff);
        respond(2'b00, 40'h01_00000000, 1'b0);
        slot(8'hff, 8'h01);
        slot(8'hff, 8'hff);
        check("cmd0_no_err", 64'(err0 - e0), 64'h0);

        // CMD8, R7 accepted on the same cycle as a link strobe
        cmd_q.push_back({6'd8, 32'h000001AA});
        send_frame(f_cmd8);
        wait_ready();
        respond(2'b10, 40'h01_000001AA, 1'b1);
        slot(8'hff, 8'h01);
        slot(8'hff, 8'h00);
        slot(8'hff, 8'h00);
        slot(8'hff, 8'h01);
        slot(8'hff, 8'hAA);
        slot(8'hff, 8'hff);
        check("cmd8_idle", 64'(bus0.o_rsp_ready), 64'h0);

        // Bad CRC: checked instance answers 08, unchecked one accepts
        s0 = stb0; e0 = err0; s1 = stb1; e1 = err1;
        send_frame(f_cmd0_bad);
        slot(8'hff, 8'h08);
        slot(8'hff, 8'hff);
        check("bad_crc_err", 64'(err0 - e0), 64'h1);
        check("bad_crc_nostb", 64'(stb0 - s0), 64'h0);
        check("bad_crc_ready", 64'(bus0.o_rsp_ready), 64'h0);
        check("nocheck_stb", 64'(stb1 - s1), 64'h1);
        check("nocheck_err", 64'(err1 - e1), 64'h0);
        check("nocheck_ready", 64'(bus1.o_rsp_ready), 64'h1);
        check("nocheck_cmd", 64'({bus1.o_cmd, bus1.o_cmd_data}), 64'h0);
        bus0.i_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("nocheck_cs_ready", 64'(bus1.o_rsp_ready), 64'h0);
        bus0.i_cs_n = 1'b0;
        @(posedge clk); #1;

        // CMD55 with R1b, busy for three byte slots
        cmd_q.push_back({6'd55, 32'h0});
        send_frame(f_cmd55);
        wait_ready();
        bus0.i_busy = 1'b1;
        respond(2'b01, 40'h00_00000000, 1'b0);
        slot(8'hff, 8'h00);
        slot(8'hff, 8'h00);
        slot(8'hff, 8'h00);
        slot(8'hff, 8'h00);
        bus0.i_busy = 1'b0;
        @(posedge clk); #1;
        slot(8'hff, 8'hff);
        check("r1b_idle", 64'(bus0.o_ll_byte), 64'hff);

        // Stray bytes, then an aborted frame, then a full CMD0
        s0 = stb0; e0 = err0;
        slot(8'hff, 8'hff);
        slot(8'h3f, 8'hff);
        slot(8'hc5, 8'hff);
        check("stray_nostb", 64'(stb0 - s0), 64'h0);
        check("stray_ready", 64'(bus0.o_rsp_ready), 64'h0);
        slot(8'h40, 8'hff);
        slot(8'h00, 8'hff);
        slot(8'h00, 8'hff);
        bus0.i_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("cs_ll_byte", 64'(bus0.o_ll_byte), 64'hff);
        bus0.i_cs_n = 1'b0;
        @(posedge clk); #1;
        cmd_q.push_back({6'd0, 32'h0});
        send_frame(f_cmd0);
        wait_ready();
        check("cs_one_stb", 64'(stb0 - s0), 64'h1);
        check("cs_no_err", 64'(err0 - e0), 64'h0);
        respond(2'b00, 40'h01_00000000, 1'b0);
        slot(8'hff, 8'h01);
        slot(8'hff, 8'hff);

        // Asynchronous reset in the middle of an R7
        cmd_q.push_back({6'd8, 32'h000001AA});
        send_frame(f_cmd8);
        wait_ready();
        respond(2'b10, 40'h01_000001AA, 1'b0);
        slot(8'hff, 8'h01);
        slot(8'hff, 8'h00);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ll_byte", 64'(bus0.o_ll_byte), 64'hff);
        check("arst_ready", 64'(bus0.o_rsp_ready), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        cmd_q.push_back({6'd0, 32'h0});
        send_frame(f_cmd0);
        wait_ready();
        respond(2'b00, 40'h01_00000000, 1'b0);
        slot(8'hff, 8'h01);
        slot(8'hff, 8'hff);

        repeat (3) @(posedge clk);
        #1;
        check("miso_q_empty", 64'(miso_q.size()), 64'h0);
        check("cmd_q_empty", 64'(cmd_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
